ascon_io_ctrl: RTL and testbench
================================

ASCON_IO_CTRL -- requirements
Module: ascon_io_ctrl

Interface
REQ-001 SHALL have parameter K, default 128, meaning key width in bits.
REQ-002 SHALL have parameter Y, default 128, meaning text (PT/CT) width in bits.
REQ-003 SHALL have parameter L, default 128, meaning associated-data width in bits.
REQ-004 SHALL have parameter W, default 8, meaning beat width in bits per transfer; K, Y, L and 128 must all be multiples of W, else elaboration error.
REQ-005 SHALL have ports, clock and reset first: clk in 1 system clock; rst in 1 reset.
REQ-006 SHALL use one clock; rst is asynchronous and active-low.
REQ-007 SHALL have host ports: mode_i in 1 (0 encrypt, 1 decrypt); in_data in W; in_valid in 1; in_ready out 1; out_data out W; out_valid out 1; out_ready in 1; busy out 1.
REQ-008 SHALL have core ports: core_key out K; core_nonce out 128; core_ad out L; core_text out Y; core_enc_start out 1; core_dec_start out 1; core_res in Y; core_tag in 128; core_done in 1.
REQ-009 SHALL have auth ports: auth_valid out 1; auth_ok out 1.

Function
REQ-010 SHALL implement FSM states IDLE, LD_KEY, LD_NONCE, LD_AD, LD_TEXT, LD_TAG, START, WAIT, OUT_RES, OUT_TAG.
REQ-011 SHALL, in IDLE, assert in_ready; on the first accepted beat, latch mode_i, store the beat as key MSB chunk and enter LD_KEY.
REQ-012 SHALL accept a beat only when in_valid and in_ready are both high, shifting it in MSB-chunk-first (matching existing bit-serial MSB-first order).
REQ-013 SHALL load fields in order key (K/W beats), nonce (128/W), AD (L/W), text (Y/W), using one beat counter that clears on each field change.
REQ-014 SHALL, on the last text beat, go to LD_TAG if decrypt mode and AUTH enabled, else START.
REQ-015 SHALL drive exactly one core_enc_start or core_dec_start pulse (per latched mode) of one cycle in START, then enter WAIT.
REQ-016 SHALL hold in_ready low in START, WAIT, OUT_RES and OUT_TAG; in_valid is ignored there.
REQ-017 SHALL sample core_done only in WAIT; on core_done, capture core_res and core_tag and enter OUT_RES the next cycle.
REQ-018 SHALL emit Y/W result beats and then 128/W tag beats, MSB chunk first, with out_valid high.
REQ-019 SHALL advance a beat only on out_valid and out_ready; when out_ready is low, out_data and out_valid hold stable.
REQ-020 SHALL return to IDLE after the last tag beat is accepted, so back-to-back messages need no idle cycle beyond one.
REQ-021 SHALL drive busy high in every state except IDLE.
REQ-022 SHALL drive core_key, core_nonce, core_ad and core_text continuously from the load registers.

Reset
REQ-023 SHALL, on rst low at any time including mid-load or mid-output, force IDLE immediately.
REQ-024 SHALL clear all registers and counters to 0 on reset.
REQ-025 SHALL reset outputs to: in_ready 0, then 1 on the first clk after release; out_valid 0; out_data 0; start pulses 0; busy 0; auth_valid 0; auth_ok 0.

Configuration
REQ-026 SHALL support macro ASCON_IO_AUTH_EN.
REQ-027 SHALL, when ASCON_IO_AUTH_EN is defined, in decrypt mode load a 128-bit expected tag in LD_TAG after the text, compare it with core_tag on core_done, and drive auth_ok accordingly with auth_valid high from OUT_RES entry until IDLE.
REQ-028 SHALL, when ASCON_IO_AUTH_EN is undefined, have no LD_TAG state, and tie auth_valid and auth_ok to 0.

Structure
REQ-029 SHALL place the FSM state enum, the mode encoding and a beat-count helper function in shared package ascon_pkg.
REQ-030 SHALL implement shifting in one sub-module ascon_beat_shifter, parametrised by width and W and instantiated per load field and for the output path.

Verification
REQ-031 SHALL cover: W=8, encrypt, key 000102..0F, nonce 101112..1F, AD 202122..2F, PT 303132..3F -> 64 beats accepted, one core_enc_start pulse one cycle after the last beat, core_key == 000102..0F.
REQ-032 SHALL cover: core_done with core_res A5A5..A5 and tag 0F0F..0F -> 16 beats of A5 then 16 beats of 0F, then busy falls.
REQ-033 SHALL cover: out_ready low for 3 cycles mid-result -> out_data held and no beat lost or repeated.
REQ-034 SHALL cover: rst low after 20 load beats -> IDLE, busy 0, outputs at reset values; the next message loads correctly.
REQ-035 SHALL cover, with ASCON_IO_AUTH_EN defined and decrypt mode: expected tag equal to core_tag -> auth_ok 1; expected tag with one bit flipped -> auth_ok 0; auth_valid 1 in both cases.
REQ-036 SHALL cover: W=1 with K=160 -> 160+128+L+Y serial beats accepted; output bit order matches MSB-first.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared FSM state and mode encodings plus beat arithmetic for the Ascon host I/O controller.
// LD_TAG is only part of the state set when ASCON_IO_AUTH_EN is defined.
package ascon_pkg;

   typedef enum logic [3:0] {
      IDLE,
      LD_KEY,
      LD_NONCE,
      LD_AD,
      LD_TEXT,
`ifdef ASCON_IO_AUTH_EN
      LD_TAG,
`endif
      START,
      WAIT,
      OUT_RES,
      OUT_TAG
   } state_t;

   typedef enum logic {
      MODE_ENC = 1'b0,
      MODE_DEC = 1'b1
   } mode_t;

   localparam int TAG_W = 128;
   localparam int CNT_W = 16;

   function automatic int beat_count(input int width, input int w);
      return width / w;
   endfunction

endpackage

// File: rtl/ascon_beat_shifter.sv
// Register filled or drained W bits per beat, most significant chunk first.
// A parallel load wins over a shift in the same cycle.
module ascon_beat_shifter #(
   parameter int WIDTH = 128,
   parameter int W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift,
   input  logic [W-1:0]     beat_in,
   output logic [WIDTH-1:0] data,
   output logic [W-1:0]     beat_out
);

   logic [WIDTH-1:0] shifted;

   generate
      if (WIDTH == W) begin : g_single
         assign shifted = beat_in;
      end else begin : g_multi
         assign shifted = {data[WIDTH-W-1:0], beat_in};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data <= '0;
      end else if (load) begin
         data <= load_data;
      end else if (shift) begin
         data <= shifted;
      end
   end

   assign beat_out = data[WIDTH-1 -: W];

endmodule

// File: rtl/ascon_io_ctrl.sv
// Beat-serial host front end for an Ascon core: loads key/nonce/AD/text, starts the core, streams result+tag.
// Optional decrypt tag check is compiled in with ASCON_IO_AUTH_EN; outputs hold while out_ready is low.
module ascon_io_ctrl #(
   parameter int K = 128,
   parameter int Y = 128,
   parameter int L = 128,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         mode_i,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy,
   output logic [K-1:0] core_key,
   output logic [127:0] core_nonce,
   output logic [L-1:0] core_ad,
   output logic [Y-1:0] core_text,
   output logic         core_enc_start,
   output logic         core_dec_start,
   input  logic [Y-1:0] core_res,
   input  logic [127:0] core_tag,
   input  logic         core_done,
   output logic         auth_valid,
   output logic         auth_ok
);
   import ascon_pkg::*;

   generate
      if ((K % W) != 0 || (Y % W) != 0 || (L % W) != 0 || (TAG_W % W) != 0) begin : g_bad_w
         $error("ascon_io_ctrl: K, Y, L and 128 must be multiples of W");
      end
   endgenerate

   localparam int KB = beat_count(K, W);
   localparam int NB = beat_count(TAG_W, W);
   localparam int AB = beat_count(L, W);
   localparam int YB = beat_count(Y, W);

   state_t           state, state_nxt;
   mode_t            mode;
   logic [CNT_W-1:0] cnt, field_max;
   logic             armed, acc, ohs, last;
   logic [W-1:0]     key_beat_unused, nonce_beat_unused, ad_beat_unused, text_beat_unused;
   logic [Y+127:0]   out_data_unused;

   assign acc  = in_valid && in_ready;
   assign ohs  = out_valid && out_ready;
   assign last = (cnt == field_max);

   // The key field counts from IDLE because the first key beat is taken there.
   always_comb begin
      field_max = '0;
      case (state)
         IDLE, LD_KEY:     field_max = CNT_W'(KB - 1);
         LD_NONCE:         field_max = CNT_W'(NB - 1);
         LD_AD:            field_max = CNT_W'(AB - 1);
         LD_TEXT, OUT_RES: field_max = CNT_W'(YB - 1);
         OUT_TAG:          field_max = CNT_W'(NB - 1);
`ifdef ASCON_IO_AUTH_EN
         LD_TAG:           field_max = CNT_W'(NB - 1);
`endif
         default:          field_max = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (acc) state_nxt = last ? LD_NONCE : LD_KEY;
         LD_KEY:   if (acc && last) state_nxt = LD_NONCE;
         LD_NONCE: if (acc && last) state_nxt = LD_AD;
         LD_AD:    if (acc && last) state_nxt = LD_TEXT;
`ifdef ASCON_IO_AUTH_EN
         LD_TEXT:  if (acc && last) state_nxt = (mode == MODE_DEC) ? LD_TAG : START;
         LD_TAG:   if (acc && last) state_nxt = START;
`else
         LD_TEXT:  if (acc && last) state_nxt = START;
`endif
         START:    state_nxt = WAIT;
         WAIT:     if (core_done) state_nxt = OUT_RES;
         OUT_RES:  if (ohs && last) state_nxt = OUT_TAG;
         OUT_TAG:  if (ohs && last) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready       = 1'b0;
      out_valid      = 1'b0;
      busy           = 1'b1;
      core_enc_start = 1'b0;
      core_dec_start = 1'b0;
      auth_valid     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = armed;
            busy     = 1'b0;
         end
         LD_KEY, LD_NONCE, LD_AD, LD_TEXT: in_ready = armed;
`ifdef ASCON_IO_AUTH_EN
         LD_TAG: in_ready = armed;
`endif
         START: begin
            core_enc_start = (mode == MODE_ENC);
            core_dec_start = (mode == MODE_DEC);
         end
         OUT_RES, OUT_TAG: begin
            out_valid = 1'b1;
`ifdef ASCON_IO_AUTH_EN
            auth_valid = (mode == MODE_DEC);
`endif
         end
         default: ;
      endcase
   end

   // armed keeps in_ready low until the first clock after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         armed <= 1'b0;
         mode  <= MODE_ENC;
         cnt   <= '0;
      end else begin
         armed <= 1'b1;
         if (state == IDLE && acc) mode <= mode_t'(mode_i);
         if (acc || ohs) cnt <= last ? '0 : cnt + CNT_W'(1);
      end
   end

   ascon_beat_shifter #(.WIDTH(K), .W(W)) u_key (
      .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
      .shift(acc && (state == IDLE || state == LD_KEY)), .beat_in(in_data),
      .data(core_key), .beat_out(key_beat_unused)
   );

   ascon_beat_shifter #(.WIDTH(TAG_W), .W(W)) u_nonce (
      .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
      .shift(acc && state == LD_NONCE), .beat_in(in_data),
      .data(core_nonce), .beat_out(nonce_beat_unused)
   );

   ascon_beat_shifter #(.WIDTH(L), .W(W)) u_ad (
      .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
      .shift(acc && state == LD_AD), .beat_in(in_data),
      .data(core_ad), .beat_out(ad_beat_unused)
   );

   ascon_beat_shifter #(.WIDTH(Y), .W(W)) u_text (
      .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
      .shift(acc && state == LD_TEXT), .beat_in(in_data),
      .data(core_text), .beat_out(text_beat_unused)
   );

   // Result and tag go out as one continuous stream, result first.
   ascon_beat_shifter #(.WIDTH(Y + TAG_W), .W(W)) u_out (
      .clk(clk), .rst(rst), .load(state == WAIT && core_done), .load_data({core_res, core_tag}),
      .shift(ohs), .beat_in('0),
      .data(out_data_unused), .beat_out(out_data)
   );

`ifdef ASCON_IO_AUTH_EN
   logic [127:0] exp_tag;
   logic [W-1:0] tag_beat_unused;
   logic         tag_match;

   ascon_beat_shifter #(.WIDTH(TAG_W), .W(W)) u_tag (
      .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
      .shift(acc && state == LD_TAG), .beat_in(in_data),
      .data(exp_tag), .beat_out(tag_beat_unused)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) tag_match <= 1'b0;
      else if (state == WAIT && core_done) tag_match <= (exp_tag == core_tag);
   end

   assign auth_ok = auth_valid && tag_match;
`else
   assign auth_ok = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_io_ctrl.sv
// Randomized self-checking bench: a W=8 instance and a W=1/K=160 instance share stimulus, selected by sel.
module tb_ascon_io_ctrl;

`ifdef ASCON_IO_AUTH_EN
   localparam bit AUTH = 1'b1;
`else
   localparam bit AUTH = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, mode_i, in_valid, out_ready, core_done;
   logic [7:0]   in_data;
   logic [127:0] core_res, core_tag;
   int           sel;
   int           checks = 0;
   int           failures = 0;

   always #5 clk = ~clk;

   logic         rdy_a, ov_a, busy_a, enc_a, dec_a, av_a, ok_a;
   logic [7:0]   od_a;
   logic [127:0] key_a, nonce_a, ad_a, text_a;
   logic         rdy_b, ov_b, busy_b, enc_b, dec_b, av_b, ok_b;
   logic [0:0]   od_b;
   logic [159:0] key_b;
   logic [127:0] nonce_b, ad_b, text_b;

   ascon_io_ctrl u_dut_a (
      .clk(clk), .rst(rst), .mode_i(mode_i), .in_data(in_data),
      .in_valid(in_valid && sel == 0), .in_ready(rdy_a),
      .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready && sel == 0), .busy(busy_a),
      .core_key(key_a), .core_nonce(nonce_a), .core_ad(ad_a), .core_text(text_a),
      .core_enc_start(enc_a), .core_dec_start(dec_a), .core_res(core_res), .core_tag(core_tag),
      .core_done(core_done && sel == 0), .auth_valid(av_a), .auth_ok(ok_a)
   );

   ascon_io_ctrl #(.K(160), .Y(128), .L(128), .W(1)) u_dut_b (
      .clk(clk), .rst(rst), .mode_i(mode_i), .in_data(in_data[0]),
      .in_valid(in_valid && sel == 1), .in_ready(rdy_b),
      .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready && sel == 1), .busy(busy_b),
      .core_key(key_b), .core_nonce(nonce_b), .core_ad(ad_b), .core_text(text_b),
      .core_enc_start(enc_b), .core_dec_start(dec_b), .core_res(core_res), .core_tag(core_tag),
      .core_done(core_done && sel == 1), .auth_valid(av_b), .auth_ok(ok_b)
   );

   logic         rdy_m, ov_m, busy_m, enc_m, dec_m, av_m, ok_m;
   logic [7:0]   od_m;
   logic [159:0] key_m;
   logic [127:0] nonce_m, ad_m, text_m;

   always_comb begin
      if (sel == 1) begin
         {rdy_m, ov_m, busy_m, enc_m, dec_m, av_m, ok_m} = {rdy_b, ov_b, busy_b, enc_b, dec_b, av_b, ok_b};
         od_m = {7'b0, od_b};
         key_m = key_b;
         {nonce_m, ad_m, text_m} = {nonce_b, ad_b, text_b};
      end else begin
         {rdy_m, ov_m, busy_m, enc_m, dec_m, av_m, ok_m} = {rdy_a, ov_a, busy_a, enc_a, dec_a, av_a, ok_a};
         od_m = od_a;
         key_m = {32'b0, key_a};
         {nonce_m, ad_m, text_m} = {nonce_a, ad_a, text_a};
      end
   end

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Beat k of an nbits-long MSB-first stream, w bits wide.
   function automatic logic [7:0] beat_of(input logic [1023:0] v, input int nbits, input int w, input int k);
      logic [1023:0] t;
      t = v >> (nbits - w * (k + 1));
      return (w == 1) ? {7'b0, t[0]} : t[7:0];
   endfunction

   task automatic send(input logic [1023:0] msg, input int nbits, input logic mode, input int limit);
      int w   = (sel == 1) ? 1 : 8;
      int nb  = nbits / w;
      int idx = 0;
      int cyc = 0;
      bit v;
      if (limit < nb) nb = limit;
      mode_i = mode;
      while (idx < nb && cyc < nb * 20 + 100) begin
         @(negedge clk);
         cyc++;
         if (idx > 0) mode_i = ~mode;
         v = ($urandom_range(0, 3) != 0);
         in_valid = v;
         in_data  = beat_of(msg, nbits, w, idx);
         if (v && rdy_m) idx++;
      end
      chk("beats_accepted", idx, nb);
   endtask

   task automatic recv(input logic [255:0] exp, input int w, input int stall_at, input logic exp_av);
      int nb = 256 / w;
      int idx = 0;
      int cyc = 0;
      int stalls = 0;
      bit r;
      logic [1023:0] v;
      v = {768'b0, exp};
      while (idx < nb && cyc < nb * 20 + 100) begin
         if (idx == stall_at && stalls < 3) begin
            r = 1'b0;
            stalls++;
         end else begin
            r = ($urandom_range(0, 4) != 0);
         end
         out_ready = r;
         chk("out_valid", ov_m, 1);
         chk("out_data", od_m, beat_of(v, 256, w, idx));
         chk("auth_valid_hold", av_m, exp_av);
         if (r && ov_m) idx++;
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      chk("beats_emitted", idx, nb);
   endtask

   task automatic run_msg(input logic mode, input logic [159:0] key,
                          input logic [127:0] nonce, ad, text, etag, res, tag, input int stall_at);
      int kbits = (sel == 1) ? 160 : 128;
      int w     = (sel == 1) ? 1 : 8;
      int nbits;
      logic [1023:0] msg;
      logic exp_av, exp_ok;
      if (sel == 0) key[159:128] = '0;
      msg = {864'b0, key};
      msg = (msg << 128) | {896'b0, nonce};
      msg = (msg << 128) | {896'b0, ad};
      msg = (msg << 128) | {896'b0, text};
      nbits = kbits + 384;
      exp_av = AUTH && mode;
      exp_ok = exp_av && (etag == tag);
      if (exp_av) begin
         msg = (msg << 128) | {896'b0, etag};
         nbits += 128;
      end
      send(msg, nbits, mode, 1 << 20);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      chk("enc_start", enc_m, !mode);
      chk("dec_start", dec_m, mode);
      chk("in_ready_start", rdy_m, 0);
      chk("busy_start", busy_m, 1);
      chk("core_key", key_m, key);
      chk("core_nonce", nonce_m, nonce);
      chk("core_ad", ad_m, ad);
      chk("core_text", text_m, text);
      @(negedge clk);
      chk("start_single", {enc_m, dec_m}, 0);
      repeat ($urandom_range(0, 4)) begin
         chk("in_ready_wait", rdy_m, 0);
         @(negedge clk);
      end
      core_res  = res;
      core_tag  = tag;
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      in_valid  = 1'b0;
      core_res  = ~res;
      core_tag  = ~tag;
      chk("out_valid_entry", ov_m, 1);
      chk("auth_valid", av_m, exp_av);
      chk("auth_ok", ok_m, exp_ok);
      recv({res, tag}, w, stall_at, exp_av);
      chk("busy_end", busy_m, 0);
      chk("out_valid_end", ov_m, 0);
      chk("in_ready_idle", rdy_m, 1);
      chk("auth_valid_end", av_m, 0);
   endtask

   function automatic logic [127:0] r128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [127:0] k, n, a, t, rr, tg;
      logic [1023:0] junk;
      logic m;
      rst = 1'b0; sel = 0; mode_i = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; core_done = 1'b0; core_res = '0; core_tag = '0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s;
         #1;
         chk("rst_in_ready", rdy_m, 0);
         chk("rst_out_valid", ov_m, 0);
         chk("rst_out_data", od_m, 0);
         chk("rst_busy", busy_m, 0);
         chk("rst_starts", {enc_m, dec_m}, 0);
         chk("rst_auth", {av_m, ok_m}, 0);
      end
      sel = 0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("release_in_ready", rdy_m, 0);
      @(negedge clk);
      chk("first_clk_in_ready_a", rdy_m, 1);
      sel = 1;
      #1;
      chk("first_clk_in_ready_b", rdy_m, 1);
      sel = 0;

      // Directed message with counting byte fields and a 3-cycle stall inside the result.
      for (int i = 0; i < 16; i++) begin
         k[127 - 8 * i -: 8] = 8'(i);
         n[127 - 8 * i -: 8] = 8'(16 + i);
         a[127 - 8 * i -: 8] = 8'(32 + i);
         t[127 - 8 * i -: 8] = 8'(48 + i);
      end
      rr = {16{8'hA5}};
      tg = {16{8'h0F}};
      run_msg(1'b0, {32'b0, k}, n, a, t, tg, rr, tg, 5);

      tg = r128();
      run_msg(1'b1, {32'b0, r128()}, r128(), r128(), r128(), tg, r128(), tg, -1);
      run_msg(1'b1, {32'b0, r128()}, r128(), r128(), r128(),
              tg ^ (128'b1 << $urandom_range(0, 127)), r128(), tg, 9);

      for (int i = 0; i < 4; i++) begin
         m  = 1'($urandom);
         tg = r128();
         run_msg(m, {32'b0, r128()}, r128(), r128(), r128(),
                 ($urandom_range(0, 1) == 1) ? tg : ~tg, r128(), tg, $urandom_range(0, 31));
      end

      // Reset in the middle of loading, then a full message.
      for (int i = 0; i < 32; i++) junk[32 * i +: 32] = $urandom;
      send(junk, 512, 1'b0, 20);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("midrst_busy", busy_m, 0);
      chk("midrst_in_ready", rdy_m, 0);
      chk("midrst_out_valid", ov_m, 0);
      chk("midrst_out_data", od_m, 0);
      chk("midrst_core_key", key_m, 0);
      chk("midrst_auth", {av_m, ok_m}, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ready_again", rdy_m, 1);
      tg = r128();
      run_msg(1'b0, {32'b0, r128()}, r128(), r128(), r128(), tg, r128(), tg, 0);

      // Bit-serial instance with a 160-bit key.
      sel = 1;
      @(negedge clk);
      tg = r128();
      run_msg(1'b0, {$urandom, r128()}, r128(), r128(), r128(), tg, r128(), tg, 40);
      tg = r128();
      run_msg(1'b1, {$urandom, r128()}, r128(), r128(), r128(), tg, r128(), tg, 200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      failures++;
      $display("FAIL watchdog expired after checks=%0d", checks);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
